// File: rtl/m_cycle_sequencer.sv
// T-step / M-cycle timing sequencer for the CPU control unit, with stall and HALT handling.
// Optional per-instruction M-cycle counter output is built when M_CYCLE_SEQ_PERF_EN is defined.
module m_cycle_sequencer #(
    parameter int STEP_WIDTH  = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Enable,
    input  logic                   i_IR_Fetch,
    input  logic                   i_Stall,
    input  logic                   i_Halt_Req,
    input  logic                   i_Wake,
    output logic [STEP_WIDTH-1:0]  o_Cycle_Step,
    output logic [COUNT_WIDTH-1:0] o_Cycle_Count,
    output logic                   o_M_Cycle_End,
    output logic                   o_Halted,
    output logic                   o_Overrun
`ifdef M_CYCLE_SEQ_PERF_EN
    ,
    output logic [3:0]             o_Instr_M_Cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_HALT
    } state_t;

    localparam logic [STEP_WIDTH-1:0]  STEP_ONE  = STEP_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    state_t state;
    logic   last_step;
    logic   cycle_end;

    assign last_step = o_Cycle_Step[STEP_WIDTH-1];

    // STALL is only ever occupied on the last step; the release clock completes the M-cycle.
    assign cycle_end     = i_Enable & (state != ST_HALT) & last_step & ~i_Stall;
    assign o_M_Cycle_End = cycle_end;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state         <= ST_RUN;
            o_Cycle_Step  <= STEP_ONE;
            o_Cycle_Count <= COUNT_ONE;
            o_Halted      <= 1'b0;
            o_Overrun     <= 1'b0;
        end else if (i_Enable) begin
            case (state)
                ST_HALT: begin
                    if (i_Wake) begin
                        state    <= ST_RUN;
                        o_Halted <= 1'b0;
                    end
                end
                default: begin
                    if (!last_step) begin
                        o_Cycle_Step <= o_Cycle_Step << 1;
                    end else if (i_Stall) begin
                        state <= ST_STALL;
                    end else begin
                        state        <= ST_RUN;
                        o_Cycle_Step <= STEP_ONE;
                        if (i_IR_Fetch) begin
                            o_Cycle_Count <= COUNT_ONE;
                            // A wake arriving with the HALT fetch cancels the halt outright.
                            if (i_Halt_Req && !i_Wake) begin
                                state    <= ST_HALT;
                                o_Halted <= 1'b1;
                            end
                        end else if (o_Cycle_Count[COUNT_WIDTH-1]) begin
                            o_Cycle_Count <= COUNT_ONE;
                            o_Overrun     <= 1'b1;
                        end else begin
                            o_Cycle_Count <= o_Cycle_Count << 1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef M_CYCLE_SEQ_PERF_EN
    logic [3:0] perf_cnt;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Counts completed M-cycles; the fetch cycle itself is included in the latched total.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            perf_cnt         <= 4'd0;
            o_Instr_M_Cycles <= 4'd0;
        end else if (cycle_end) begin
            if (i_IR_Fetch) begin
                o_Instr_M_Cycles <= sat_inc(perf_cnt);
                perf_cnt         <= 4'd0;
            end else begin
                perf_cnt <= sat_inc(perf_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_m_cycle_sequencer.sv
// Self-checking bench for m_cycle_sequencer: directed scenarios plus random stimulus against
// an index-based reference model. Perf output is checked when M_CYCLE_SEQ_PERF_EN is defined.
module tb_m_cycle_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, fetch, stall, hreq, wake;
    logic [3:0] step;
    logic [7:0] count;
    logic       m_end, halted, overrun;
`ifdef M_CYCLE_SEQ_PERF_EN
    logic [3:0] instr;
`endif

    m_cycle_sequencer #(.STEP_WIDTH(4), .COUNT_WIDTH(8)) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Enable     (en),
        .i_IR_Fetch   (fetch),
        .i_Stall      (stall),
        .i_Halt_Req   (hreq),
        .i_Wake       (wake),
        .o_Cycle_Step (step),
        .o_Cycle_Count(count),
        .o_M_Cycle_End(m_end),
        .o_Halted     (halted),
        .o_Overrun    (overrun)
`ifdef M_CYCLE_SEQ_PERF_EN
        ,
        .o_Instr_M_Cycles(instr)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: T-step index 0..3, M-cycle index 0..7, halt and overrun flags.
    int m_t = 0;
    int m_m = 0;
    bit m_halt = 1'b0;
    bit m_ovr  = 1'b0;
`ifdef M_CYCLE_SEQ_PERF_EN
    int m_perf = 0;
    int m_perf_out = 0;
`endif

    function automatic logic [3:0] exp_step();
        return 4'(1 << m_t);
    endfunction

    function automatic logic [7:0] exp_count();
        return 8'(1 << m_m);
    endfunction

    function automatic logic exp_end();
        return en && !m_halt && (m_t == 3) && !stall;
    endfunction

    task automatic model_update();
        if (rst) begin
            m_t = 0; m_m = 0; m_halt = 1'b0; m_ovr = 1'b0;
`ifdef M_CYCLE_SEQ_PERF_EN
            m_perf = 0; m_perf_out = 0;
`endif
        end else if (!en) begin
            // frozen
        end else if (m_halt) begin
            if (wake) m_halt = 1'b0;
        end else if (m_t < 3) begin
            m_t = m_t + 1;
        end else if (!stall) begin
            m_t = 0;
`ifdef M_CYCLE_SEQ_PERF_EN
            if (fetch) begin
                m_perf_out = (m_perf + 1 > 15) ? 15 : m_perf + 1;
                m_perf = 0;
            end else begin
                m_perf = (m_perf + 1 > 15) ? 15 : m_perf + 1;
            end
`endif
            if (fetch) begin
                m_m = 0;
                if (hreq && !wake) m_halt = 1'b1;
            end else if (m_m == 7) begin
                m_m = 0;
                m_ovr = 1'b1;
            end else begin
                m_m = m_m + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; fetch = 1'b0; stall = 1'b0; hreq = 1'b0; wake = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        #1;
        n_cmp++; if (step !== 4'b0001) begin n_fail++; $display("FAIL reset_step: got %b want 0001", step); end
        n_cmp++; if (count !== 8'b00000001) begin n_fail++; $display("FAIL reset_count: got %b want 00000001", count); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_cmp++; if (m_end !== 1'b0) begin n_fail++; $display("FAIL reset_end: got %b want 0", m_end); end
    endtask

    task automatic test_step_sequence();
        logic e;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            e = (i % 4 == 0);
            n_cmp++; if (m_end !== e) begin n_fail++; $display("FAIL seq_end clk%0d: got %b want %b", i, m_end, e); end
            tick();
            n_cmp++; if (step !== 4'(1 << (i % 4))) begin n_fail++; $display("FAIL seq_step clk%0d: got %b want %b", i, step, 4'(1 << (i % 4))); end
            if (i % 4 == 0) begin
                n_cmp++; if (count !== 8'(1 << (i / 4))) begin n_fail++; $display("FAIL seq_count clk%0d: got %b want %b", i, count, 8'(1 << (i / 4))); end
            end
        end
    endtask

    task automatic test_five_cycle_instr();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            fetch = (i > 16);
            if (i == 17) begin
                n_cmp++; if (count !== 8'b00010000) begin n_fail++; $display("FAIL instr5_pre_count: got %b want 00010000", count); end
            end
            tick();
        end
        fetch = 1'b0;
        n_cmp++; if (count !== 8'b00000001) begin n_fail++; $display("FAIL instr5_count: got %b want 00000001", count); end
        n_cmp++; if (step !== 4'b0001) begin n_fail++; $display("FAIL instr5_step: got %b want 0001", step); end
`ifdef M_CYCLE_SEQ_PERF_EN
        n_cmp++; if (instr !== 4'd5) begin n_fail++; $display("FAIL instr5_perf: got %0d want 5", instr); end
`endif
    endtask

    task automatic test_stall();
        do_reset();
        en = 1'b1;
        repeat (7) tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (m_end !== 1'b0) begin n_fail++; $display("FAIL stall_end%0d: got %b want 0", i, m_end); end
            tick();
            n_cmp++; if (step !== 4'b1000 || count !== 8'b00000010) begin n_fail++; $display("FAIL stall_hold%0d: got %b/%b want 1000/00000010", i, step, count); end
        end
        stall = 1'b0;
        #1;
        n_cmp++; if (m_end !== 1'b1) begin n_fail++; $display("FAIL stall_release_end: got %b want 1", m_end); end
        tick();
        n_cmp++; if (count !== 8'b00000100 || step !== 4'b0001) begin n_fail++; $display("FAIL stall_release: got %b/%b want 0001/00000100", step, count); end
    endtask

    task automatic test_halt();
        do_reset();
        en = 1'b1; fetch = 1'b1; hreq = 1'b1;
        repeat (4) tick();
        fetch = 1'b0; hreq = 1'b0;
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_enter: got %b want 1", halted); end
        for (int i = 0; i < 10; i++) begin
            fetch = 1'($urandom_range(0, 1)); stall = 1'($urandom_range(0, 1));
            tick();
            n_cmp++; if (halted !== 1'b1 || step !== 4'b0001 || count !== 8'b00000001) begin
                n_fail++; $display("FAIL halt_hold%0d: got h=%b %b/%b want h=1 0001/00000001", i, halted, step, count);
            end
        end
        fetch = 1'b0; stall = 1'b0; wake = 1'b1;
        tick();
        wake = 1'b0;
        n_cmp++; if (halted !== 1'b0 || step !== 4'b0001) begin n_fail++; $display("FAIL halt_wake: got h=%b %b want h=0 0001", halted, step); end
        tick();
        n_cmp++; if (step !== 4'b0010) begin n_fail++; $display("FAIL halt_resume: got %b want 0010", step); end
    endtask

    task automatic test_wake_at_boundary();
        do_reset();
        en = 1'b1; fetch = 1'b1; hreq = 1'b1; wake = 1'b1;
        repeat (4) tick();
        fetch = 1'b0; hreq = 1'b0; wake = 1'b0;
        n_cmp++; if (halted !== 1'b0 || count !== 8'b00000001) begin n_fail++; $display("FAIL wake_win: got h=%b %b want h=0 00000001", halted, count); end
        tick();
        n_cmp++; if (step !== 4'b0010) begin n_fail++; $display("FAIL wake_win_step: got %b want 0010", step); end
    endtask

    task automatic test_overrun();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 28) begin
                n_cmp++; if (count !== 8'b10000000 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: got %b ovr=%b want 10000000 ovr=0", count, overrun); end
            end
        end
        n_cmp++; if (count !== 8'b00000001 || overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_wrap: got %b ovr=%b want 00000001 ovr=1", count, overrun); end
        for (int i = 0; i < 20; i++) begin
            fetch = 1'($urandom_range(0, 1));
            tick();
        end
        fetch = 1'b0;
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        do_reset();
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
`ifdef M_CYCLE_SEQ_PERF_EN
        en = 1'b1;
        repeat (68) tick();
        fetch = 1'b1;
        repeat (4) tick();
        fetch = 1'b0;
        n_cmp++; if (instr !== 4'd15) begin n_fail++; $display("FAIL perf_sat: got %0d want 15", instr); end
`endif
    endtask

    task automatic test_enable_freeze();
        do_reset();
        en = 1'b1;
        tick(); tick();
        en = 1'b0; fetch = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (m_end !== 1'b0) begin n_fail++; $display("FAIL en_end%0d: got %b want 0", i, m_end); end
            tick();
            n_cmp++; if (step !== 4'b0100 || count !== 8'b00000001) begin n_fail++; $display("FAIL en_hold%0d: got %b/%b want 0100/00000001", i, step, count); end
        end
        en = 1'b1; fetch = 1'b0;
        tick();
        en = 1'b0;
        #1;
        n_cmp++; if (m_end !== 1'b0) begin n_fail++; $display("FAIL en_last_end: got %b want 0", m_end); end
        tick();
        n_cmp++; if (step !== 4'b1000) begin n_fail++; $display("FAIL en_last_hold: got %b want 1000", step); end
        en = 1'b1;
        #1;
        n_cmp++; if (m_end !== 1'b1) begin n_fail++; $display("FAIL en_resume_end: got %b want 1", m_end); end
        tick();
        n_cmp++; if (count !== 8'b00000010 || step !== 4'b0001) begin n_fail++; $display("FAIL en_resume: got %b/%b want 0001/00000010", step, count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; fetch = 1'b1; hreq = 1'b1;
        repeat (4) tick();
        fetch = 1'b0; hreq = 1'b0;
        tick();
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL rstmid_halt_pre: got %b want 1", halted); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (halted !== 1'b0 || step !== 4'b0001 || count !== 8'b00000001) begin
            n_fail++; $display("FAIL rstmid_halt: got h=%b %b/%b want h=0 0001/00000001", halted, step, count);
        end
        repeat (7) tick();
        stall = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        n_cmp++; if (step !== 4'b0001 || count !== 8'b00000001) begin n_fail++; $display("FAIL rstmid_stall: got %b/%b want 0001/00000001", step, count); end
        tick();
        n_cmp++; if (step !== 4'b0010) begin n_fail++; $display("FAIL rstmid_run: got %b want 0010", step); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 9) != 0);
            fetch = ($urandom_range(0, 4) == 0);
            stall = ($urandom_range(0, 3) == 0);
            hreq  = ($urandom_range(0, 2) == 0);
            wake  = ($urandom_range(0, 4) == 0);
            #1;
            n_cmp++; if (m_end !== exp_end()) begin n_fail++; $display("FAIL rnd_end@%0d: got %b want %b", i, m_end, exp_end()); end
            tick();
            n_cmp++; if (step !== exp_step()) begin n_fail++; $display("FAIL rnd_step@%0d: got %b want %b", i, step, exp_step()); end
            n_cmp++; if (count !== exp_count()) begin n_fail++; $display("FAIL rnd_count@%0d: got %b want %b", i, count, exp_count()); end
            n_cmp++; if (halted !== m_halt) begin n_fail++; $display("FAIL rnd_halted@%0d: got %b want %b", i, halted, m_halt); end
            n_cmp++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL rnd_overrun@%0d: got %b want %b", i, overrun, m_ovr); end
`ifdef M_CYCLE_SEQ_PERF_EN
            n_cmp++; if (instr !== 4'(m_perf_out)) begin n_fail++; $display("FAIL rnd_perf@%0d: got %0d want %0d", i, instr, m_perf_out); end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; fetch = 1'b0; stall = 1'b0; hreq = 1'b0; wake = 1'b0;
        test_reset();
        test_step_sequence();
        test_five_cycle_instr();
        test_stall();
        test_halt();
        test_wake_at_boundary();
        test_overrun();
        test_enable_freeze();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/m_cycle_sequencer.md
Name: m_cycle_sequencer

Overview:
- Timing sequencer for the CPU control unit. Generates the one-hot T-step vector and the one-hot M-cycle count consumed by every instruction microcode block.
- Restarts the M-cycle count when the active microcode signals its IR fetch cycle.
- Handles memory/DMA stall and the HALT low-power state.
- Sits between the top-level CPU clocking and the microcode decoders.

Parameters:
- STEP_WIDTH, 4, number of T-steps per M-cycle; one-hot width of o_Cycle_Step.
- COUNT_WIDTH, 8, maximum M-cycles per instruction; one-hot width of o_Cycle_Count.

Ports:
- i_Clk  input  1  system clock; all state updates on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Enable  input  1  clock enable; low freezes all state and outputs.
- i_IR_Fetch  input  1  OR of microcode o_IR_Fetch. High means the current M-cycle is the opcode fetch that ends the instruction.
- i_Stall  input  1  memory/DMA not ready; extends the current M-cycle.
- i_Halt_Req  input  1  HALT instruction executing; sampled at the fetch boundary.
- i_Wake  input  1  interrupt pending; exits HALT.
- o_Cycle_Step  output  STEP_WIDTH  one-hot T-step within the M-cycle.
- o_Cycle_Count  output  COUNT_WIDTH  one-hot M-cycle index within the instruction.
- o_M_Cycle_End  output  1  combinational. High during the last T-step when the M-cycle will complete this clock.
- o_Halted  output  1  high while in the HALT state.
- o_Overrun  output  1  sticky error: the count ran past the MSB without an IR fetch.

Behaviour:
- Reset (synchronous, highest priority):
  - o_Cycle_Step=0001, o_Cycle_Count=00000001, state RUN.
  - o_Halted=0, o_Overrun=0.
  - Reset mid-instruction or mid-HALT applies the same values on the next edge.
- i_Enable=0: no register changes; outputs hold and o_M_Cycle_End=0.
- States:
  - RUN: step rotates left one bit per enabled clock, 0001->0010->0100->1000->0001.
  - STALL: entered from RUN when step==1000 and i_Stall=1. Step and count hold at their current values; o_M_Cycle_End=0. The clock where i_Stall is seen low returns to RUN, and the M-cycle completes on that same clock. A stall of N cycles extends the M-cycle by exactly N clocks.
  - HALT: step held at 0001, count held at 00000001, o_Halted=1. i_Wake=1 -> RUN on the next clock, with step 0001 -> 0010 on the following clock.
- i_Stall is ignored at steps other than the last; it affects only the last step.
- o_M_Cycle_End = i_Enable & RUN & step[MSB] & ~i_Stall.
- On M-cycle end:
  - If i_IR_Fetch=1: count <- 00000001. If in addition i_Halt_Req=1 and i_Wake=0, enter HALT.
  - If i_Halt_Req=1 and i_Wake=1 on the same clock: HALT is not entered (wake wins).
  - If i_IR_Fetch=0: count shifts left one bit.
  - If i_IR_Fetch=0 and count[MSB]=1: count wraps to 00000001 and o_Overrun is set. o_Overrun clears only on reset.
- i_Wake outside HALT: ignored.
- Invariant: step and count are always exactly one-hot, including after wrap and HALT exit.

Optional Feature:
- Macro: M_CYCLE_SEQ_PERF_EN.
- Enabled:
  - Adds output o_Instr_M_Cycles [3:0].
  - A binary counter increments on every M-cycle end and reloads 0 at each fetch end.
  - The value completed at each fetch end (cycles including the fetch) is latched to o_Instr_M_Cycles, for microcode timing checks against published instruction timings.
  - Reset value 0. Saturates at 15.
- Disabled: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then 8 enabled clocks with i_IR_Fetch=0 -> step sequence 0001,0010,0100,1000,0001..., count=00000010 after clock 4 and 00000100 after clock 8, o_M_Cycle_End high on clocks 4 and 8 only.
- 5-M-cycle instruction (IR fetch asserted while count=00010000) -> at the end of the 20th clock, count=00000001 and step=0001; with PERF_EN, o_Instr_M_Cycles=5.
- i_Stall high for 3 clocks at step 1000 of count 00000010 -> step and count hold 3 extra clocks, no o_M_Cycle_End during the stall, count=00000100 one clock after stall release.
- HALT: i_Halt_Req=1 with IR fetch at M-cycle end -> o_Halted=1, outputs frozen at 0001/00000001 for 10 clocks; i_Wake pulse -> o_Halted=0 on the next clock, stepping resumes. Repeat with i_Wake=1 at the boundary -> HALT never entered.
- Overrun: run 8 M-cycles without i_IR_Fetch -> count wraps to 00000001, o_Overrun=1 and stays 1 until i_Reset.
- i_Enable low for 5 clocks mid-M-cycle, and i_Reset asserted during HALT/STALL -> enable low freezes all outputs; reset returns all outputs to reset values on the next edge.
